// File: rtl/task_arb_pkg.sv
// Shared types and defaults for the task arbiter.
//   state_t      : arbiter FSM state encoding
//   NREQ_DEF     : default number of requesters
//   TMO_CYC_DEF  : default watchdog limit in clk cycles (used only when
//                  TASK_ARB_TIMEOUT_EN is defined)
package task_arb_pkg;

    localparam int NREQ_DEF    = 4;
    localparam int TMO_CYC_DEF = 200;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

endpackage

// File: rtl/task_arbiter_if.sv
// Handshake bundle between the requesters, the shared worker and the arbiter.
//   req      : per-requester job request level
//   grant    : one-hot owner of the worker
//   ack      : one-cycle completion pulse to the owner
//   err      : one-cycle pulse alongside ack when the job was aborted
//   wk_start : one-cycle start pulse to the worker
//   wk_clr   : one-cycle pulse returning the worker to idle
//   wk_busy  : worker busy status
//   wk_done  : worker done level, held until wk_clr
// slave modport is the arbiter side; master modport drives requests and
// worker status.
interface task_arbiter_if #(
    parameter int NREQ = task_arb_pkg::NREQ_DEF
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] ack;
    logic            err;
    logic            wk_start;
    logic            wk_clr;
    logic            wk_busy;
    logic            wk_done;

    modport slave (
        input  req, wk_busy, wk_done,
        output grant, ack, err, wk_start, wk_clr
    );

    modport master (
        output req, wk_busy, wk_done,
        input  grant, ack, err, wk_start, wk_clr
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req_i   : request vector
//   ptr_i   : index of the last owner; search begins at ptr_i+1 (mod NREQ)
//   win_o   : one-hot winner, all-zero when no request
//   valid_o : any request present
module rr_pick
    import task_arb_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] win_o,
    output logic            valid_o
);

    logic [PW-1:0] idx;

    always_comb begin
        win_o   = '0;
        valid_o = 1'b0;
        idx     = '0;
        // Walk NREQ slots starting just after the last owner; the last
        // owner itself is visited last, so it only wins when alone.
        for (int k = 1; k <= NREQ; k++) begin
            idx = PW'((int'(ptr_i) + k) % NREQ);
            if (!valid_o && req_i[idx]) begin
                win_o[idx] = 1'b1;
                valid_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/task_arbiter.sv
// Round-robin arbiter sharing one worker among NREQ requesters.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : task_arbiter_if.slave (req/grant/ack/err, worker start/clr/busy/done)
// Optional feature: define TASK_ARB_TIMEOUT_EN to add a watchdog that forces
// release with err=1 after TMO_CYC cycles in WAIT without wk_done. Without
// the macro WAIT waits indefinitely and err is tied low.
//
// state   | meaning
// IDLE    | no owner; arbitrate when worker is idle and not done
// START   | owner latched, wk_start high this cycle
// WAIT    | worker running, waiting for wk_done
// RELEASE | ack to owner and wk_clr to worker this cycle
module task_arbiter
    import task_arb_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int TMO_CYC = TMO_CYC_DEF
) (
    input  logic          clk,
    input  logic          rst,
    task_arbiter_if.slave bus
);

    localparam int PW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TMO_CYC < 2) begin : g_param_check
        $error("task_arbiter: NREQ must be 2..8 and TMO_CYC at least 2");
    end

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            wk_start_q, wk_start_d;
    logic            wk_clr_q, wk_clr_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_idx;
    logic [NREQ-1:0] pick;
    logic            pick_vld;

`ifdef TASK_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYC) + 1;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            err_q, err_d;
`endif

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .win_o   (pick),
        .valid_o (pick_vld)
    );

    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                owner_idx = PW'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        ack_d      = '0;
        wk_start_d = 1'b0;
        wk_clr_d   = 1'b0;
`ifdef TASK_ARB_TIMEOUT_EN
        tmo_d      = tmo_q;
        err_d      = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                // A done level seen here belongs to a stale job; hold off
                // until the worker has been cleared.
                if (pick_vld && !bus.wk_busy && !bus.wk_done) begin
                    grant_d    = pick;
                    wk_start_d = 1'b1;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
`ifdef TASK_ARB_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            ST_WAIT: begin
                // Done wins over a coincident timeout.
                if (bus.wk_done) begin
                    state_d  = ST_RELEASE;
                    ack_d    = grant_q;
                    wk_clr_d = 1'b1;
                end
`ifdef TASK_ARB_TIMEOUT_EN
                else if (tmo_q == TW'(TMO_CYC - 1)) begin
                    state_d  = ST_RELEASE;
                    ack_d    = grant_q;
                    wk_clr_d = 1'b1;
                    err_d    = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
`endif
            end
            ST_RELEASE: begin
                ptr_d   = owner_idx;
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            ack_q      <= '0;
            wk_start_q <= 1'b0;
            wk_clr_q   <= 1'b0;
            ptr_q      <= PW'(NREQ - 1);
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            wk_start_q <= wk_start_d;
            wk_clr_q   <= wk_clr_d;
            ptr_q      <= ptr_d;
        end
    end

`ifdef TASK_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.grant    = grant_q;
    assign bus.ack      = ack_q;
    assign bus.wk_start = wk_start_q;
    assign bus.wk_clr   = wk_clr_q;

endmodule

// File: tb/tb_task_arbiter.sv
module tb_task_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    task_arbiter_if #(.NREQ(NREQ)) bus ();

    task_arbiter #(.NREQ(NREQ), .TMO_CYC(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [NREQ-1:0] v;
        logic            e;
        int              c;
    } exp_t;

    exp_t exp_g[$];
    exp_t exp_a[$];
    logic [NREQ-1:0] gr_log[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int ack_cnt     = 0;

    logic [NREQ-1:0] dir_req = '0;
    logic [NREQ-1:0] rnd_req = '0;
    logic stale_done = 1'b0;
    logic w_done     = 1'b0;
    logic w_busy     = 1'b0;
    logic w_active   = 1'b0;
    logic hang       = 1'b0;
    logic rand_en    = 1'b0;
    int   fixed_delay = 0;
    int   drop_pct    = 0;
    int   w_cnt       = 0;

    assign bus.req     = dir_req | rnd_req;
    assign bus.wk_done = w_done | stale_done;
    assign bus.wk_busy = w_busy;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Worker: on wk_start raise done after a delay, drop it on wk_clr.
    always @(negedge clk) begin
        if (rst) begin
            w_done = 1'b0; w_busy = 1'b0; w_active = 1'b0; w_cnt = 0;
        end else if (bus.wk_clr) begin
            w_done = 1'b0; w_busy = 1'b0; w_active = 1'b0;
        end else if (bus.wk_start) begin
            w_busy = 1'b1;
            if (!hang) begin
                w_active = 1'b1;
                w_cnt = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 8));
            end
        end else if (w_active) begin
            if (w_cnt <= 1) begin
                w_done = 1'b1; w_busy = 1'b0; w_active = 1'b0;
            end else begin
                w_cnt--;
            end
        end
    end

    // Random requesters: hold until ack, sometimes drop while granted,
    // sometimes keep requesting after ack.
    always @(negedge clk) begin
        if (rst) begin
            rnd_req = '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.ack[i]) begin
                    if (!rand_en || $urandom_range(0, 1) == 0) rnd_req[i] = 1'b0;
                end else if (bus.grant[i]) begin
                    if (rnd_req[i] && int'($urandom_range(0, 99)) < drop_pct) rnd_req[i] = 1'b0;
                end else if (!rnd_req[i] && rand_en && $urandom_range(0, 3) == 0) begin
                    rnd_req[i] = 1'b1;
                end
            end
        end
    end

    // Reference model: one job at a time; arbitration when free, worker idle
    // and not done; winner is the first requester after the last owner.
    logic            m_busy  = 1'b0;
    logic            m_acked = 1'b0;
    int              m_ptr   = NREQ - 1;
    int              m_owner = 0;
    int              m_gcyc  = 0;
    int              m_rel   = 0;
    int              m_sh    = 0;
    int              m_p     = 0;
    logic            m_found = 1'b0;
    logic [2*NREQ-1:0] m_dbl;
    exp_t            mm;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_busy = 1'b0; m_acked = 1'b0; m_ptr = NREQ - 1;
        end else if (m_busy && !m_acked) begin
            if (cyc >= m_gcyc + 2 && bus.wk_done) begin
                mm.v = '0; mm.v[m_owner] = 1'b1; mm.e = 1'b0; mm.c = cyc;
                exp_a.push_back(mm);
                m_acked = 1'b1; m_rel = cyc;
            end
`ifdef TASK_ARB_TIMEOUT_EN
            else if (cyc == m_gcyc + TMO + 1) begin
                mm.v = '0; mm.v[m_owner] = 1'b1; mm.e = 1'b1; mm.c = cyc;
                exp_a.push_back(mm);
                m_acked = 1'b1; m_rel = cyc;
            end
`endif
        end else if (m_busy) begin
            if (cyc == m_rel + 1) begin
                m_busy = 1'b0; m_ptr = m_owner;
            end
        end else if (bus.req != '0 && !bus.wk_done && !bus.wk_busy) begin
            m_sh  = (m_ptr + 1) % NREQ;
            m_dbl = {bus.req, bus.req} >> m_sh;
            m_found = 1'b0; m_p = 0;
            for (int p = 0; p < NREQ; p++) begin
                if (!m_found && m_dbl[p]) begin m_found = 1'b1; m_p = p; end
            end
            m_owner = (m_sh + m_p) % NREQ;
            mm.v = '0; mm.v[m_owner] = 1'b1; mm.e = 1'b0; mm.c = cyc;
            exp_g.push_back(mm);
            m_gcyc = cyc; m_busy = 1'b1; m_acked = 1'b0;
        end
    end

    // Monitor: pops expectations whenever the DUT presents a grant or ack.
    logic [NREQ-1:0] prev_g = '0;
    logic [NREQ-1:0] prev_a = '0;
    exp_t            mt;

    always @(negedge clk) begin
        if (rst) begin
            prev_g = '0; prev_a = '0;
        end else begin
            if (bus.grant != '0 && prev_g == '0) begin
                gr_log.push_back(bus.grant);
                chk("grant_onehot", int'($onehot(bus.grant)), 1);
                if (exp_g.size() == 0) begin
                    chk("grant_unexpected", int'(bus.grant), 0);
                end else begin
                    mt = exp_g.pop_front();
                    chk("grant", int'(bus.grant), int'(mt.v));
                    chk("grant_cycle", cyc, mt.c);
                    chk("wk_start_with_grant", int'(bus.wk_start), 1);
                end
            end else begin
                if (bus.wk_start) chk("wk_start_stray", int'(bus.wk_start), 0);
                if (prev_g != '0 && bus.grant != '0 && bus.grant != prev_g)
                    chk("grant_stable", int'(bus.grant), int'(prev_g));
                if (prev_g != '0 && bus.grant == '0 && prev_a == '0)
                    chk("grant_drop_without_ack", int'(prev_a), int'(prev_g));
            end
            if (bus.ack != '0) begin
                ack_cnt++;
                if (exp_a.size() == 0) begin
                    chk("ack_unexpected", int'(bus.ack), 0);
                end else begin
                    mt = exp_a.pop_front();
                    chk("ack", int'(bus.ack), int'(mt.v));
                    chk("ack_err", int'(bus.err), int'(mt.e));
                    chk("ack_cycle", cyc, mt.c);
                    chk("wk_clr_with_ack", int'(bus.wk_clr), 1);
                    chk("grant_at_ack", int'(bus.grant), int'(bus.ack));
                end
            end else begin
                if (bus.wk_clr) chk("wk_clr_stray", int'(bus.wk_clr), 0);
                if (bus.err)    chk("err_stray", int'(bus.err), 0);
            end
            prev_g = bus.grant;
            prev_a = bus.ack;
        end
    end

    task automatic wait_acks(input int n, input int limit, input string name,
                             output logic [NREQ-1:0] last_ack);
        int seen = 0;
        last_ack = '0;
        for (int k = 0; k < limit && seen < n; k++) begin
            @(negedge clk);
            if (bus.ack != '0) begin seen++; last_ack = bus.ack; end
        end
        if (seen < n) chk({name, "_ack_timeout"}, seen, n);
        dir_req = '0;
    endtask

    task automatic wait_grant(input int limit, input string name);
        int k = 0;
        while (bus.grant == '0 && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (bus.grant == '0) chk({name, "_grant_timeout"}, int'(bus.grant != '0), 1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        exp_g.delete(); exp_a.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_grant"},    int'(bus.grant), 0);
        chk({name, "_ack"},      int'(bus.ack), 0);
        chk({name, "_err"},      int'(bus.err), 0);
        chk({name, "_wk_start"}, int'(bus.wk_start), 0);
        chk({name, "_wk_clr"},   int'(bus.wk_clr), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] la;
        int acks_before;

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // Single requester, worker done 3 cycles after start.
        fixed_delay = 3;
        dir_req = 4'b0001;
        wait_acks(1, 50, "single", la);
        chk("single_ack", int'(la), 1);
        @(negedge clk);
        chk("single_grant_cleared", int'(bus.grant), 0);

        // All four requesting continuously from a fresh pointer.
        pulse_reset();
        gr_log.delete();
        fixed_delay = 0;
        dir_req = 4'b1111;
        wait_acks(5, 300, "contention", la);
        chk("contention_count", gr_log.size(), 5);
        if (gr_log.size() == 5) begin
            chk("contention_g0", int'(gr_log[0]), 4'b0001);
            chk("contention_g1", int'(gr_log[1]), 4'b0010);
            chk("contention_g2", int'(gr_log[2]), 4'b0100);
            chk("contention_g3", int'(gr_log[3]), 4'b1000);
            chk("contention_g4", int'(gr_log[4]), 4'b0001);
        end

        // Stale done level blocks arbitration.
        stale_done = 1'b1;
        dir_req = 4'b0010;
        repeat (10) @(negedge clk);
        chk("stale_no_grant", int'(bus.grant), 0);
        gr_log.delete();
        stale_done = 1'b0;
        wait_acks(1, 50, "stale", la);
        chk("stale_ack", int'(la), 4'b0010);

        // Request dropped during WAIT still gets its ack.
        fixed_delay = 6;
        dir_req = 4'b0100;
        wait_grant(20, "drop");
        repeat (2) @(negedge clk);
        dir_req = '0;
        wait_acks(1, 50, "drop", la);
        chk("drop_ack", int'(la), 4'b0100);

        // Random traffic.
        repeat (2) @(negedge clk);
        fixed_delay = 0;
        drop_pct = 20;
        rand_en = 1'b1;
        repeat (3000) @(negedge clk);
        rand_en = 1'b0;
        for (int k = 0; k < 500 && (rnd_req != '0 || bus.grant != '0); k++) @(negedge clk);
        chk("random_drained", int'(rnd_req | bus.grant), 0);
        drop_pct = 0;
        repeat (2) @(negedge clk);

        // Worker that never finishes.
        hang = 1'b1;
        dir_req = 4'b0001;
`ifdef TASK_ARB_TIMEOUT_EN
        wait_acks(1, 100, "timeout", la);
        chk("timeout_ack", int'(la), 1);
        hang = 1'b0;
        repeat (2) @(negedge clk);
`else
        wait_grant(20, "hang");
        acks_before = ack_cnt;
        repeat (1000) @(negedge clk);
        chk("hang_grant_held", int'(bus.grant), 1);
        chk("hang_no_ack", ack_cnt, acks_before);
        dir_req = '0;
        hang = 1'b0;
        pulse_reset();
`endif

        // Reset in the middle of WAIT.
        fixed_delay = 20;
        dir_req = 4'b0001;
        wait_grant(20, "midreset");
        repeat (3) @(negedge clk);
        acks_before = ack_cnt;
        #2;
        rst = 1'b1;
        exp_g.delete(); exp_a.delete();
        #1;
        check_idle_outputs("midreset");
        dir_req = 4'b1001;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("midreset_no_ack", ack_cnt, acks_before);
        fixed_delay = 2;
        gr_log.delete();
        wait_acks(1, 50, "postreset", la);
        chk("postreset_ack", int'(la), 4'b0001);
        if (gr_log.size() > 0) chk("postreset_grant", int'(gr_log[0]), 4'b0001);
        else chk("postreset_grant_seen", gr_log.size(), 1);

        repeat (5) @(negedge clk);
        chk("exp_grant_drained", exp_g.size(), 0);
        chk("exp_ack_drained", exp_a.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/task_arbiter.md
TASK_ARBITER -- requirements
Module: task_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one worker (2..8).
REQ-002 Parameter TMO_CYC, default 200: watchdog limit in clk cycles (only used with TASK_ARB_TIMEOUT_EN).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  NREQ  per-requester job request level, held until matching ack.
REQ-006 grant  output  NREQ  one-hot owner of the worker; all-zero when none.
REQ-007 ack  output  NREQ  one-cycle pulse to the owner on job completion.
REQ-008 err  output  1  one-cycle pulse coincident with ack when the job was aborted by watchdog.
REQ-009 wk_start  output  1  one-cycle start pulse to the worker.
REQ-010 wk_clr  output  1  one-cycle pulse returning the worker from its finish state to idle.
REQ-011 wk_busy  input  1  worker busy status.
REQ-012 wk_done  input  1  worker done level; stays high until wk_clr.

Function
REQ-013 FSM states: IDLE, START, WAIT, RELEASE; registered state, registered outputs.
REQ-014 IDLE: if any req bit set and wk_busy=0 and wk_done=0, latch winner into grant and go START; else stay.
REQ-015 Winner: round-robin, search starts at index ptr+1 (mod NREQ), first set req bit wins.
REQ-016 START: wk_start=1 for exactly this one cycle; go WAIT next cycle.
REQ-017 WAIT: on wk_done=1 go RELEASE; else stay.
REQ-018 RELEASE: ack[owner]=1, wk_clr=1 for this one cycle; ptr<=owner; grant<=0; go IDLE.
REQ-019 Latency: req set in IDLE at edge k -> grant visible after edge k+1, wk_start high between edges k+1 and k+2.
REQ-020 grant held constant from START through RELEASE inclusive; never more than one bit set.
REQ-021 req dropped while granted is ignored: job runs to completion and ack still issues.
REQ-022 A requester holding req after its ack is re-eligible only at its round-robin turn; back-to-back same winner only if no other req set.
REQ-023 wk_done=1 observed in IDLE blocks arbitration (stale worker); no wk_start issued.
REQ-024 Minimum job period IDLE->IDLE is 4 cycles when wk_done returns one cycle after wk_start.

Reset
REQ-025 On rst: state=IDLE, grant=0, ack=0, err=0, wk_start=0, wk_clr=0, ptr=NREQ-1 (index 0 highest first priority), watchdog count=0.
REQ-026 rst mid-job aborts immediately; no ack issued for the aborted job; worker recovery is the worker's own reset.

Configuration
REQ-027 Macro TASK_ARB_TIMEOUT_EN defined: counter clears on START, increments each WAIT cycle; reaching TMO_CYC-1 without wk_done forces RELEASE with err=1.
REQ-028 wk_done and timeout in the same cycle: treated as done, err=0.
REQ-029 Macro undefined: no counter, WAIT waits indefinitely, err tied 0.

Structure
REQ-030 Package task_arb_pkg holds: state enum/encoding constants, default NREQ, default TMO_CYC.
REQ-031 One sub-module rr_pick: combinational round-robin picker (req, ptr -> one-hot winner, valid).

Verification
REQ-032 Single: req=0001 -> grant=0001 next cycle, one wk_start; wk_done after 3 cycles -> ack=0001 + wk_clr one cycle, grant=0.
REQ-033 Contention: req=1111 held continuously -> grant order 0001,0010,0100,1000,0001; each ack exactly once per job.
REQ-034 Stale worker: wk_done=1 at IDLE with req=0010 -> no grant until wk_done=0, then grant=0010.
REQ-035 Timeout (macro on, TMO_CYC=16): wk_done never rises -> ack+err at 16th WAIT cycle; macro off -> grant held, no ack after 1000 cycles.
REQ-036 Reset mid-WAIT: rst pulse -> all outputs 0 asynchronously, no ack; next req=1000 with req=0001 -> grant=0001.
REQ-037 Drop: req=0100 deasserted during WAIT -> ack=0100 still issued on wk_done.
